alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 116 +++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue: registers ALU requests into a one-deep issue stage and queues
// results in a credit-checked FIFO returned with their tags.
`ifndef ALU_CODE_W
`define ALU_CODE_W 4
`define ALU_ADD 4'h0
`define ALU_SLL 4'h1
`define ALU_SLT 4'h2
`define ALU_XOR 4'h4
`define ALU_SRL 4'h5
`define ALU_OR  4'h6
`define ALU_AND 4'h7
`define ALU_SUB 4'h8
`endif

module alu_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [DATA_WIDTH-1:0]  req_a,
    input  logic [DATA_WIDTH-1:0]  req_b,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic [DATA_WIDTH-1:0]  alu_in_a,
    output logic [DATA_WIDTH-1:0]  alu_in_b,
    output logic [`ALU_CODE_W-1:0] alu_code,
    input  logic [DATA_WIDTH-1:0]  alu_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    output logic                   busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                   r_init;
    logic                   r_stage_valid;
    logic [DATA_WIDTH-1:0]  r_a;
    logic [DATA_WIDTH-1:0]  r_b;
    logic [`ALU_CODE_W-1:0] r_code;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [DATA_WIDTH-1:0]  r_mem_data [DEPTH];
    logic [TAG_WIDTH-1:0]   r_mem_tag  [DEPTH];
    logic                   w_accept;
    logic                   w_pop;
    logic [CW:0]            w_used;
    logic [`ALU_CODE_W-1:0] w_code;

    always_comb begin
        w_code = `ALU_ADD;
        case (req_op)
            3'd0:    w_code = `ALU_SLL;
            3'd1:    w_code = `ALU_SRL;
            3'd2:    w_code = `ALU_ADD;
            3'd3:    w_code = `ALU_SUB;
            3'd4:    w_code = `ALU_OR;
            3'd5:    w_code = `ALU_XOR;
            3'd6:    w_code = `ALU_AND;
            default: w_code = `ALU_SLT;
        endcase
    end

    // The in-flight stage holds a credit, so the FIFO can never be written while full.
    assign w_used    = {1'b0, r_count} + (CW+1)'(r_stage_valid);
    assign req_ready = r_init && (w_used < (CW+1)'(DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = r_count != '0;
    assign w_pop     = rsp_valid && rsp_ready;
    assign busy      = r_stage_valid || rsp_valid;
    assign rsp_data  = rsp_valid ? r_mem_data[r_rd_ptr] : '0;
    assign rsp_tag   = rsp_valid ? r_mem_tag[r_rd_ptr] : '0;
    assign alu_in_a  = r_a;
    assign alu_in_b  = r_b;
    assign alu_code  = r_code;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_init        <= 1'b0;
            r_stage_valid <= 1'b0;
            r_a           <= '0;
            r_b           <= '0;
            r_code        <= `ALU_ADD;
            r_tag         <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
        end else begin
            r_init        <= 1'b1;
            r_stage_valid <= w_accept;
            if (w_accept) begin
                r_a    <= req_a;
                r_b    <= req_b;
                r_code <= w_code;
                r_tag  <= req_tag;
            end
            r_wr_ptr <= r_wr_ptr + PW'(r_stage_valid);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(r_stage_valid) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (r_stage_valid) begin
            r_mem_data[r_wr_ptr] <= alu_out;
            r_mem_tag[r_wr_ptr]  <= r_tag;
        end
    end
endmodule
